// File: rtl/item_spawner_pkg.sv
// Shared grid geometry, colours and spawner state encoding.
// Pure declarations: no latency, no flow control.
package item_spawner_pkg;

   localparam int COORD_W = 4;
   localparam int GRID_W  = 16;
   localparam int GRID_H  = 16;

   localparam logic [2:0] ITEM_COLOUR = 3'b100;
   localparam logic [2:0] BG_COLOUR   = 3'b000;

   // Galois feedback mask for x^16 + x^14 + x^13 + x^11
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   typedef enum logic [1:0] {
      GEN    = 2'd0,
      CHECK  = 2'd1,
      DRAW   = 2'd2,
      ACTIVE = 2'd3
   } state_t;

   function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
      return {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_TAPS : 16'h0000);
   endfunction

endpackage

// File: rtl/item_spawner_lfsr16.sv
// Free-running 16-bit Galois LFSR with enable; a zero seed is replaced by 1.
// Latency: one step per enabled cycle; no backpressure.
module lfsr16
   import item_spawner_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        en,
   output logic [15:0] state
);

   localparam logic [15:0] INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= INIT;
      end else if (en) begin
         state <= lfsr_step(state);
      end
   end

endmodule

// File: rtl/item_spawner.sv
// Picks a free grid cell for the food item (random, then linear scan) and draws it.
// Latency: eaten edge to draw_req >= 3 cycles, draw_done to item_valid 1 cycle; stalls in DRAW until draw_done.
module item_spawner #(
   parameter int          GRID_W      = item_spawner_pkg::GRID_W,
   parameter int          GRID_H      = item_spawner_pkg::GRID_H,
   parameter int          COORD_W     = item_spawner_pkg::COORD_W,
   parameter logic [15:0] LFSR_SEED   = 16'hACE1,
   parameter int          MAX_TRIES   = 8,
   parameter logic [2:0]  ITEM_COLOUR = item_spawner_pkg::ITEM_COLOUR
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               item_eaten,
   input  logic [COORD_W-1:0] head_x,
   input  logic [COORD_W-1:0] head_y,
   output logic [COORD_W-1:0] occ_x,
   output logic [COORD_W-1:0] occ_y,
   input  logic               occ_hit,
   output logic               draw_req,
   output logic [COORD_W-1:0] draw_x,
   output logic [COORD_W-1:0] draw_y,
   output logic [2:0]         draw_colour,
   input  logic               draw_done,
   output logic [COORD_W-1:0] item_x,
   output logic [COORD_W-1:0] item_y,
   output logic               item_valid,
   output logic [7:0]         spawn_count
);
   import item_spawner_pkg::*;

   localparam int TRY_W = $clog2(MAX_TRIES + 1);
   localparam logic [TRY_W-1:0] TRY_MAX = TRY_W'(MAX_TRIES);

   state_t             state, state_nxt;
   logic [15:0]        lfsr;
   logic               lfsr_unused;
   logic [COORD_W-1:0] cand_x, cand_y, cand_x_nxt, cand_y_nxt;
   logic [COORD_W-1:0] item_x_nxt, item_y_nxt;
   logic [TRY_W-1:0]   tries, tries_nxt;
   logic               item_valid_nxt;
   logic [7:0]         spawn_count_nxt;
   logic               item_eaten_q;
   logic               eaten_rise;
   logic               reject;

   lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
      .clk   (clk),
      .resetn(resetn),
      .en    (1'b1),
      .state (lfsr)
   );

   assign lfsr_unused = ^lfsr[15:2*COORD_W];

   assign eaten_rise  = item_eaten & ~item_eaten_q;
   assign reject      = (int'(cand_x) >= GRID_W) || (int'(cand_y) >= GRID_H) || occ_hit
                        || ((cand_x == head_x) && (cand_y == head_y));

   assign occ_x       = cand_x;
   assign occ_y       = cand_y;
   assign draw_req    = (state == DRAW);
   assign draw_x      = cand_x;
   assign draw_y      = cand_y;
   assign draw_colour = ITEM_COLOUR;

   always_comb begin
      state_nxt       = state;
      cand_x_nxt      = cand_x;
      cand_y_nxt      = cand_y;
      tries_nxt       = tries;
      item_x_nxt      = item_x;
      item_y_nxt      = item_y;
      item_valid_nxt  = item_valid;
      spawn_count_nxt = spawn_count;
      case (state)
         GEN: begin
            state_nxt = CHECK;
            if (tries == TRY_MAX) begin
               // Scan mode: walk the grid row-major from the last candidate.
               if (int'(cand_x) >= GRID_W - 1) begin
                  cand_x_nxt = '0;
                  cand_y_nxt = (int'(cand_y) >= GRID_H - 1) ? '0 : cand_y + 1'b1;
               end else begin
                  cand_x_nxt = cand_x + 1'b1;
               end
            end else begin
               {cand_y_nxt, cand_x_nxt} = lfsr[2*COORD_W-1:0];
            end
         end
         CHECK: begin
            if (reject) begin
               state_nxt = GEN;
               tries_nxt = (tries == TRY_MAX) ? tries : tries + 1'b1;
            end else begin
               state_nxt = DRAW;
            end
         end
         DRAW: begin
            if (draw_done) begin
               state_nxt       = ACTIVE;
               item_x_nxt      = cand_x;
               item_y_nxt      = cand_y;
               item_valid_nxt  = 1'b1;
               spawn_count_nxt = spawn_count + 8'd1;
               tries_nxt       = '0;
            end
         end
         ACTIVE: begin
            if (eaten_rise) begin
               state_nxt      = GEN;
               item_valid_nxt = 1'b0;
            end
         end
         default: state_nxt = GEN;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state        <= GEN;
         cand_x       <= '0;
         cand_y       <= '0;
         tries        <= '0;
         item_x       <= '0;
         item_y       <= '0;
         item_valid   <= 1'b0;
         spawn_count  <= 8'd0;
         item_eaten_q <= 1'b0;
      end else begin
         state        <= state_nxt;
         cand_x       <= cand_x_nxt;
         cand_y       <= cand_y_nxt;
         tries        <= tries_nxt;
         item_x       <= item_x_nxt;
         item_y       <= item_y_nxt;
         item_valid   <= item_valid_nxt;
         spawn_count  <= spawn_count_nxt;
         item_eaten_q <= item_eaten;
      end
   end

endmodule

// File: tb/tb_item_spawner.sv
// Directed bench for item_spawner: default 16x16 instance plus a GRID_W=10 instance.
module tb_item_spawner;

   logic       clk = 1'b0;
   logic       resetn;
   logic       item_eaten;
   logic [3:0] head_x, head_y;
   logic [3:0] occ_x, occ_y;
   logic       occ_hit;
   logic       draw_req;
   logic [3:0] draw_x, draw_y;
   logic [2:0] draw_colour;
   logic       draw_done;
   logic [3:0] item_x, item_y;
   logic       item_valid;
   logic [7:0] spawn_count;

   logic [3:0] d2_occ_x, d2_occ_y, d2_draw_x, d2_draw_y, d2_item_x, d2_item_y;
   logic       d2_draw_req, d2_item_valid;
   logic [2:0] d2_draw_colour;
   logic [7:0] d2_spawn_count;

   logic force_occ, occ_mode, auto_done, poke_done;
   int   vec_cnt = 0;
   int   miss_cnt = 0;
   int   dcnt, cyc_rst, d2_first, d2_bad, cyc;
   logic [3:0] d2_fx, d2_fy;

   always #5 clk = ~clk;

   // Mode 1: every cell occupied except (5,9).
   assign occ_hit = occ_mode ? !((occ_x == 4'd5) && (occ_y == 4'd9)) : force_occ;

   item_spawner dut (
      .clk(clk), .resetn(resetn), .item_eaten(item_eaten),
      .head_x(head_x), .head_y(head_y), .occ_x(occ_x), .occ_y(occ_y), .occ_hit(occ_hit),
      .draw_req(draw_req), .draw_x(draw_x), .draw_y(draw_y), .draw_colour(draw_colour),
      .draw_done(draw_done), .item_x(item_x), .item_y(item_y), .item_valid(item_valid),
      .spawn_count(spawn_count)
   );

   item_spawner #(.GRID_W(10), .LFSR_SEED(16'h005C)) dut_narrow (
      .clk(clk), .resetn(resetn), .item_eaten(1'b0),
      .head_x(4'd0), .head_y(4'd0), .occ_x(d2_occ_x), .occ_y(d2_occ_y), .occ_hit(1'b0),
      .draw_req(d2_draw_req), .draw_x(d2_draw_x), .draw_y(d2_draw_y), .draw_colour(d2_draw_colour),
      .draw_done(d2_draw_req), .item_x(d2_item_x), .item_y(d2_item_y), .item_valid(d2_item_valid),
      .spawn_count(d2_spawn_count)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         miss_cnt++;
         $display("FAIL %s: got %0h, want %0h", tag, got, exp);
      end
   endtask

   task automatic wait_req(input int start, output int n);
      n = start;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!draw_req && n < 600);
   endtask

   task automatic wait_valid();
      int n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!item_valid && n < 600);
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      @(posedge clk); #1;
      resetn = 1'b1;
   endtask

   // Square-filler model (done 2 cycles after draw_req) and narrow-instance monitor.
   initial begin
      draw_done = 1'b0; dcnt = 0; cyc_rst = 0; d2_first = 0; d2_bad = 0;
      d2_fx = 4'd0; d2_fy = 4'd0;
      forever begin
         @(posedge clk); #1;
         cyc_rst = resetn ? cyc_rst + 1 : 0;
         if (!resetn || draw_done) begin
            draw_done = 1'b0; dcnt = 0;
         end else if (poke_done) begin
            draw_done = 1'b1; poke_done = 1'b0;
         end else if (draw_req && auto_done) begin
            dcnt++;
            if (dcnt == 2) draw_done = 1'b1;
         end else begin
            dcnt = 0;
         end
         if (resetn && d2_draw_req && d2_draw_x >= 4'd10) d2_bad++;
         if (resetn && d2_draw_req && d2_first == 0) begin
            d2_first = cyc_rst; d2_fx = d2_draw_x; d2_fy = d2_draw_y;
         end
      end
   end

   initial begin
      resetn = 1'b0; item_eaten = 1'b0; head_x = 4'd0; head_y = 4'd0;
      force_occ = 1'b0; occ_mode = 1'b0; auto_done = 1'b1; poke_done = 1'b0;

      #3;
      check_val("rst_valid", item_valid, 0);
      check_val("rst_req", draw_req, 0);
      check_val("rst_count", spawn_count, 0);
      check_val("rst_item", {item_x, item_y}, 8'h00);
      check_val("rst_occ", {occ_x, occ_y}, 8'h00);
      check_val("rst_colour", draw_colour, 3'b100);

      // First spawn from seed ACE1 -> candidate (1,14).
      @(posedge clk); #1;
      resetn = 1'b1;
      wait_req(0, cyc);
      check_val("first_req_cyc", cyc, 2);
      check_val("first_draw", {draw_x, draw_y}, 8'h1E);
      wait_valid();
      check_val("first_item", {item_x, item_y}, 8'h1E);
      check_val("first_valid", item_valid, 1);
      check_val("first_count", spawn_count, 1);
      check_val("narrow_first_cyc", d2_first, 4);
      check_val("narrow_first_xy", {d2_fx, d2_fy}, 8'h71);

      // Stray draw_done while ACTIVE.
      poke_done = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      check_val("stray_done_count", spawn_count, 1);
      check_val("stray_done_item", {item_x, item_y}, 8'h1E);

      // Sticky item_eaten: exactly one respawn.
      item_eaten = 1'b1;
      @(posedge clk); #1;
      check_val("eaten_drop", item_valid, 0);
      repeat (49) begin @(posedge clk); #1; end
      item_eaten = 1'b0;
      repeat (5) begin @(posedge clk); #1; end
      check_val("sticky_count", spawn_count, 2);
      check_val("sticky_valid", item_valid, 1);

      // Reset during DRAW.
      auto_done = 1'b0;
      item_eaten = 1'b1;
      wait_req(0, cyc);
      check_val("pre_rst_req", draw_req, 1);
      resetn = 1'b0;
      #2;
      check_val("async_req", draw_req, 0);
      check_val("async_valid", item_valid, 0);
      check_val("async_count", spawn_count, 0);
      item_eaten = 1'b0;
      @(posedge clk); #1;
      resetn = 1'b1;
      auto_done = 1'b1;
      wait_req(0, cyc);
      check_val("clean_req_cyc", cyc, 2);
      check_val("clean_draw", {draw_x, draw_y}, 8'h1E);
      wait_valid();
      check_val("clean_count", spawn_count, 1);

      // Three occupied CHECKs reject (1,14),(8,3),(14,4); accept (3,1).
      force_occ = 1'b1;
      do_reset();
      repeat (6) begin @(posedge clk); #1; end
      check_val("rej_no_req", draw_req, 0);
      force_occ = 1'b0;
      wait_req(6, cyc);
      check_val("rej_req_cyc", cyc, 8);
      check_val("rej_draw", {draw_x, draw_y}, 8'h31);

      // Only (5,9) free: 8 random misses, scan from (11,8) reaches (5,9).
      occ_mode = 1'b1;
      do_reset();
      wait_req(0, cyc);
      check_val("scan_req_cyc", cyc, 36);
      check_val("scan_draw", {draw_x, draw_y}, 8'h59);
      wait_valid();
      check_val("scan_item", {item_x, item_y}, 8'h59);
      check_val("scan_count", spawn_count, 1);

      check_val("narrow_bad_draws", d2_bad, 0);
      check_val("narrow_valid", d2_item_valid, 1);
      check_val("narrow_x_legal", d2_item_x < 4'd10, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule
